// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution reduction datapath:
//   - clog2          : ceiling log2 for elaboration-time sizing
//   - calc_levels    : number of pairwise adder levels for a given operand count
//   - calc_out_width : width of a full group sum (operand + tree growth + beats)
//   - level_count    : number of terms present at the input of a tree level
//   - level_offset   : bit offset of a level's terms inside the flattened tree bus
//   - acc_state_e    : accumulator FSM state encoding
// ---------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic int calc_levels(input int num_inputs);
    return clog2(num_inputs);
  endfunction

  function automatic int calc_out_width(input int data_width, input int num_inputs,
                                        input int max_beats);
    return data_width + clog2(num_inputs) + clog2(max_beats);
  endfunction

  // Terms entering level j: each level halves the count, rounding up because
  // an odd leftover term is carried through unchanged.
  function automatic int level_count(input int num_inputs, input int level);
    int count;
    count = num_inputs;
    for (int i = 0; i < level; i++) begin
      count = (count + 1) / 2;
    end
    return count;
  endfunction

  // All tree levels share one flat bus; level i terms are (data_width + i) bits
  // wide, so the offset of level j is the total size of the levels before it.
  function automatic int level_offset(input int num_inputs, input int data_width,
                                      input int level);
    int offset;
    offset = 0;
    for (int i = 0; i < level; i++) begin
      offset = offset + level_count(num_inputs, i) * (data_width + i);
    end
    return offset;
  endfunction

endpackage

// File: rtl/reduce_tree_level.sv
// ---------------------------------------------------------------------------
// reduce_tree_level
// One registered level of the signed pairwise adder tree. Adjacent terms are
// sign-extended by one bit and added; an odd leftover term is sign-extended
// and passed through. Valid and last travel alongside the data, and the whole
// level holds its contents while adv is low.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   adv       : global pipeline advance (low = hold everything)
//   in_valid  : incoming terms are a real beat
//   in_last   : incoming beat closes its group
//   in_data   : N_IN signed terms of IN_W bits, term k at [k*IN_W +: IN_W]
//   out_valid : registered valid
//   out_last  : registered last flag
//   out_data  : ceil(N_IN/2) signed terms of IN_W+1 bits
// ---------------------------------------------------------------------------
module reduce_tree_level #(
  parameter int N_IN = 2,
  parameter int IN_W = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 adv,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  input  logic [N_IN*IN_W-1:0]                 in_data,
  output logic                                 out_valid,
  output logic                                 out_last,
  output logic [((N_IN+1)/2)*(IN_W+1)-1:0]     out_data
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int OUT_W = IN_W + 1;

  logic [N_OUT*OUT_W-1:0] sum_d;

  // One extra bit per level is enough to hold the sum of two terms exactly.
  for (genvar k = 0; k < N_OUT; k++) begin : gen_pair
    if (2 * k + 1 < N_IN) begin : g_pair
      logic [IN_W-1:0] term_a;
      logic [IN_W-1:0] term_b;
      assign term_a = in_data[2*k*IN_W +: IN_W];
      assign term_b = in_data[(2*k+1)*IN_W +: IN_W];
      assign sum_d[k*OUT_W +: OUT_W] = {term_a[IN_W-1], term_a} + {term_b[IN_W-1], term_b};
    end else begin : g_pass
      logic [IN_W-1:0] term_a;
      assign term_a = in_data[2*k*IN_W +: IN_W];
      assign sum_d[k*OUT_W +: OUT_W] = {term_a[IN_W-1], term_a};
    end
  end

  // Bubbles are captured as valid = 0, so they flow through without effect
  // downstream; nothing moves while the output stage is blocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= sum_d;
    end
  end

endmodule

// File: rtl/conv_reduce_tree.sv
// ---------------------------------------------------------------------------
// conv_reduce_tree
// Pipelined signed reduction unit. Each accepted beat of NUM_INPUTS operands is
// summed by a LEVELS-deep registered adder tree, then beats are accumulated
// into one group result closed by in_last, or force-closed with out_err when a
// group reaches MAX_BEATS beats without in_last.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  : input beat present
//   in_ready  : beat accepted this cycle (combinational, = !out_valid || out_ready)
//   in_data   : NUM_INPUTS signed operands, operand k at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_last   : final beat of a group
//   out_valid : group result held in the output register
//   out_ready : downstream takes the result
//   out_data  : signed group sum, OUT_WIDTH bits
//   out_err   : group was force-closed at MAX_BEATS beats
// ---------------------------------------------------------------------------
module conv_reduce_tree
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 9,
  parameter int MAX_BEATS  = 16
) (
  input  logic                                                         clk,
  input  logic                                                         reset,
  input  logic                                                         in_valid,
  output logic                                                         in_ready,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]                             in_data,
  input  logic                                                         in_last,
  output logic                                                         out_valid,
  input  logic                                                         out_ready,
  output logic [calc_out_width(DATA_WIDTH, NUM_INPUTS, MAX_BEATS)-1:0] out_data,
  output logic                                                         out_err
);

  localparam int LEVELS    = calc_levels(NUM_INPUTS);
  localparam int OUT_WIDTH = calc_out_width(DATA_WIDTH, NUM_INPUTS, MAX_BEATS);
  localparam int TREE_W    = DATA_WIDTH + LEVELS;
  localparam int CNT_W     = clog2(MAX_BEATS);
  localparam int BUS_W     = level_offset(NUM_INPUTS, DATA_WIDTH, LEVELS + 1);
  localparam int TREE_OFF  = level_offset(NUM_INPUTS, DATA_WIDTH, LEVELS);

  logic                 adv;
  logic [BUS_W-1:0]     tree_bus;
  logic [LEVELS:0]      tree_valid;
  logic [LEVELS:0]      tree_last;
  logic [TREE_W-1:0]    tree_sum;
  logic [OUT_WIDTH-1:0] tree_sum_ext;

  acc_state_e           state_q, state_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_data_d;
  logic                 out_valid_d;
  logic                 out_err_d;
  logic [OUT_WIDTH-1:0] group_sum;
  logic                 close_group;

  // The whole datapath moves in lock-step: it only stalls when a finished
  // result is sitting in the output register and downstream is not taking it.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign tree_bus[DATA_WIDTH*NUM_INPUTS-1:0] = in_data;
  assign tree_valid[0] = in_valid;
  assign tree_last[0]  = in_last;

  // Each level reads its terms from the flat bus and writes the next level's
  // slice, one bit wider per term.
  for (genvar j = 0; j < LEVELS; j++) begin : gen_level
    localparam int N_IN    = level_count(NUM_INPUTS, j);
    localparam int N_OUT   = level_count(NUM_INPUTS, j + 1);
    localparam int IN_W    = DATA_WIDTH + j;
    localparam int IN_OFF  = level_offset(NUM_INPUTS, DATA_WIDTH, j);
    localparam int OUT_OFF = level_offset(NUM_INPUTS, DATA_WIDTH, j + 1);

    reduce_tree_level #(
      .N_IN (N_IN),
      .IN_W (IN_W)
    ) u_level (
      .clk       (clk),
      .reset     (reset),
      .adv       (adv),
      .in_valid  (tree_valid[j]),
      .in_last   (tree_last[j]),
      .in_data   (tree_bus[IN_OFF +: N_IN*IN_W]),
      .out_valid (tree_valid[j+1]),
      .out_last  (tree_last[j+1]),
      .out_data  (tree_bus[OUT_OFF +: N_OUT*(IN_W+1)])
    );
  end

  assign tree_sum     = tree_bus[TREE_OFF +: TREE_W];
  assign tree_sum_ext = {{(OUT_WIDTH - TREE_W){tree_sum[TREE_W-1]}}, tree_sum};

  // Accumulator and output register next-state. A group closes either on the
  // last flag or when this beat would be the MAX_BEATS-th of the group; in the
  // latter case the result is flagged and the next beat opens a fresh group.
  // When adv is low every register keeps its value.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_err_d   = out_err;
    group_sum   = ((state_q == ACCUM) ? acc_q : '0) + tree_sum_ext;
    close_group = tree_last[LEVELS] || (cnt_q == CNT_W'(MAX_BEATS - 1));

    if (adv) begin
      out_valid_d = 1'b0;
      if (tree_valid[LEVELS]) begin
        if (close_group) begin
          out_data_d  = group_sum;
          out_valid_d = 1'b1;
          out_err_d   = !tree_last[LEVELS];
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          acc_d   = group_sum;
          cnt_d   = cnt_q + 1'b1;
          state_d = ACCUM;
        end
      end
    end
  end

  // State, accumulator and output registers; reset drops any partial group.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_err   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_conv_reduce_tree.sv
// ---------------------------------------------------------------------------
// tb_conv_reduce_tree
// Self-checking bench for conv_reduce_tree with default parameters. A
// behavioural model (plain beat sums, a fixed-latency delay line and group
// accumulation) is compared with the DUT on every falling edge; directed
// scenarios add literal expectations for the documented cases.
// ---------------------------------------------------------------------------
module tb_conv_reduce_tree;
  import conv_pkg::*;

  localparam int DW     = 16;
  localparam int NI     = 9;
  localparam int MB     = 16;
  localparam int LEVELS = calc_levels(NI);
  localparam int OW     = calc_out_width(DW, NI, MB);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DW*NI-1:0]  in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic              out_err;

  int tests    = 0;
  int failures = 0;

  bit hold       = 0;
  bit rand_ready = 0;
  bit check_en   = 0;

  longint got_data[$];
  bit     got_err[$];

  typedef struct {
    bit     v;
    bit     last;
    longint sum;
  } beat_t;

  beat_t  pipe[LEVELS];
  bit     m_out_valid = 0;
  longint m_out_data  = 0;
  bit     m_out_err   = 0;
  longint m_acc       = 0;
  int     m_count     = 0;

  conv_reduce_tree #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .MAX_BEATS  (MB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog");
  end

  function automatic longint toLong(input logic [OW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint beatSum(input logic [DW*NI-1:0] d);
    longint s = 0;
    for (int k = 0; k < NI; k++) s += longint'($signed(d[k*DW +: DW]));
    return s;
  endfunction

  function automatic logic [DW*NI-1:0] packAll(input int v);
    logic [DW*NI-1:0] d;
    for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'(v);
    return d;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: a beat's total appears LEVELS advancing cycles after
  // acceptance, is folded into its group, and the group is emitted on last
  // or once it holds MB beats.
  always @(posedge clk or negedge reset) begin
    beat_t  tail;
    longint total;
    if (!reset) begin
      for (int i = 0; i < LEVELS; i++) pipe[i] = '{v: 0, last: 0, sum: 0};
      m_out_valid = 0;
      m_out_data  = 0;
      m_out_err   = 0;
      m_acc       = 0;
      m_count     = 0;
    end else if (!m_out_valid || out_ready) begin
      tail = pipe[LEVELS-1];
      for (int i = LEVELS - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{v: in_valid, last: in_last, sum: beatSum(in_data)};
      m_out_valid = 0;
      if (tail.v) begin
        total   = m_acc + tail.sum;
        m_count = m_count + 1;
        if (tail.last || m_count == MB) begin
          m_out_valid = 1;
          m_out_data  = total;
          m_out_err   = !tail.last;
          m_acc       = 0;
          m_count     = 0;
        end else begin
          m_acc = total;
        end
      end
    end
  end

  // Cycle-by-cycle comparison plus a log of every result handed downstream.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("in_ready", longint'(in_ready), longint'(!m_out_valid || out_ready));
      checkOutput("out_valid", longint'(out_valid), longint'(m_out_valid));
      if (m_out_valid) begin
        checkOutput("out_data", toLong(out_data), m_out_data);
        checkOutput("out_err", longint'(out_err), longint'(m_out_err));
      end
      if (reset && out_valid && out_ready) begin
        got_data.push_back(toLong(out_data));
        got_err.push_back(out_err);
      end
    end
  end

  // Downstream readiness, changed just after each rising edge.
  always @(posedge clk) begin
    #2;
    if (hold) out_ready = 0;
    else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1;
  end

  task automatic applyStimulus(input logic [DW*NI-1:0] data, input bit last);
    int waited = 0;
    bit taken  = 0;
    in_valid = 1;
    in_data  = data;
    in_last  = last;
    while (!taken && waited < 100) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 0;
    in_last  = 0;
    checkOutput("beat_accepted", longint'(taken), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitResult(output int cycles, output longint data, output bit err);
    bit seen = 0;
    cycles = 0;
    data   = 0;
    err    = 0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      seen = out_valid;
      data = toLong(out_data);
      err  = out_err;
    end
    checkOutput("result_seen", longint'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clearGot();
    got_data.delete();
    got_err.delete();
  endtask

  initial begin
    int               lat;
    longint           rdata;
    bit               rerr;
    int               sv[NI];
    logic [DW*NI-1:0] d;
    longint           bp_exp[4];

    reset     = 0;
    in_valid  = 0;
    in_last   = 0;
    in_data   = '0;
    out_ready = 1;
    @(posedge clk);
    #1;
    check_en = 1;
    checkOutput("reset_out_valid", longint'(out_valid), 0);
    checkOutput("reset_out_err", longint'(out_err), 0);
    checkOutput("reset_out_data", toLong(out_data), 0);
    checkOutput("reset_in_ready", longint'(in_ready), 1);
    idle(2);
    reset = 1;
    idle(2);

    // Single signed beat: latency and value.
    clearGot();
    sv = '{100, -50, 7, -7, 32767, -32768, 1, 0, -1};
    for (int k = 0; k < NI; k++) d[k*DW +: DW] = DW'(sv[k]);
    applyStimulus(d, 1);
    waitResult(lat, rdata, rerr);
    checkOutput("single_latency", lat, LEVELS + 1);
    checkOutput("single_data", rdata, 49);
    checkOutput("single_err", longint'(rerr), 0);
    idle(8);
    checkOutput("single_count", got_data.size(), 1);

    // Three-beat group.
    clearGot();
    applyStimulus(packAll(2), 0);
    applyStimulus(packAll(2), 0);
    applyStimulus(packAll(2), 1);
    idle(10);
    checkOutput("accum_count", got_data.size(), 1);
    if (got_data.size() > 0) checkOutput("accum_data", got_data[0], 54);

    // Backpressure on back-to-back single-beat groups.
    clearGot();
    hold = 1;
    for (int v = 1; v <= 4; v++) applyStimulus(packAll(v), 1);
    waitResult(lat, rdata, rerr);
    checkOutput("bp_first_data", rdata, 9);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", longint'(in_ready), 0);
      checkOutput("bp_hold_valid", longint'(out_valid), 1);
      checkOutput("bp_hold_data", toLong(out_data), 9);
    end
    @(posedge clk);
    #1;
    hold = 0;
    idle(12);
    bp_exp = '{9, 18, 27, 36};
    checkOutput("bp_count", got_data.size(), 4);
    for (int i = 0; i < 4 && i < got_data.size(); i++) checkOutput("bp_order", got_data[i], bp_exp[i]);

    // Force-close after MB beats; beat 17 opens the next group.
    clearGot();
    for (int i = 0; i < 17; i++) applyStimulus(packAll(-1), 0);
    applyStimulus(packAll(1), 1);
    idle(12);
    checkOutput("fc_count", got_data.size(), 2);
    if (got_data.size() >= 2) begin
      checkOutput("fc_data", got_data[0], -144);
      checkOutput("fc_err", longint'(got_err[0]), 1);
      checkOutput("fc_next_data", got_data[1], 0);
      checkOutput("fc_next_err", longint'(got_err[1]), 0);
    end

    // Most negative operands over a full group.
    clearGot();
    for (int i = 0; i < 16; i++) applyStimulus(packAll(-32768), i == 15);
    idle(12);
    checkOutput("ext_count", got_data.size(), 1);
    if (got_data.size() > 0) begin
      checkOutput("ext_data", got_data[0], -4718592);
      checkOutput("ext_err", longint'(got_err[0]), 0);
    end

    // Reset while a result is blocked and a partial group is in flight.
    clearGot();
    hold = 1;
    applyStimulus(packAll(1), 1);
    applyStimulus(packAll(5), 0);
    applyStimulus(packAll(5), 0);
    waitResult(lat, rdata, rerr);
    checkOutput("mid_pre_data", rdata, 9);
    reset = 0;
    #1;
    checkOutput("mid_reset_out_valid", longint'(out_valid), 0);
    checkOutput("mid_reset_out_err", longint'(out_err), 0);
    checkOutput("mid_reset_out_data", toLong(out_data), 0);
    checkOutput("mid_reset_in_ready", longint'(in_ready), 1);
    hold = 0;
    @(posedge clk);
    #1;
    reset = 1;
    idle(2);
    clearGot();
    applyStimulus(packAll(1), 1);
    idle(10);
    checkOutput("mid_after_count", got_data.size(), 1);
    if (got_data.size() > 0) checkOutput("mid_after_data", got_data[0], 9);

    // Randomised traffic with random downstream stalls.
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NI; k++) begin
        case ($urandom_range(0, 7))
          0:       d[k*DW +: DW] = 16'h8000;
          1:       d[k*DW +: DW] = 16'h7fff;
          default: d[k*DW +: DW] = DW'($urandom);
        endcase
      end
      applyStimulus(d, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/conv_reduce_tree.md
# conv_reduce_tree

Pipelined, parametrised signed reduction unit for the convolution datapath. Each accepted beat sums `NUM_INPUTS` packed operands through a registered pairwise adder tree. Beats are then accumulated across a group delimited by `in_last`, for example the channel-wise partial sums of one output pixel. It sits between the multiplier array and the activation/quantisation stage, and uses valid/ready handshakes with full backpressure.

## Interface
- `DATA_WIDTH`, default 16: signed width of each input operand.
- `NUM_INPUTS`, default 9: number of operands per beat, ≥2 (a 3×3 kernel by default).
- `MAX_BEATS`, default 16: maximum number of beats per group, a power of two, ≥2.
- Derived constants:
  - `LEVELS` = clog2(`NUM_INPUTS`).
  - `OUT_WIDTH` = `DATA_WIDTH` + `LEVELS` + clog2(`MAX_BEATS`).
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input beat is present.
- `in_ready`, output, 1: block accepts the beat this cycle.
- `in_data`, input, `DATA_WIDTH*NUM_INPUTS`: operand k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
- `in_last`, input, 1: marks the final beat of a group.
- `out_valid`, output, 1: the group result is valid.
- `out_ready`, input, 1: the downstream stage takes the result.
- `out_data`, output, `OUT_WIDTH`: signed group sum.
- `out_err`, output, 1: the group was force-closed at `MAX_BEATS` without seeing `in_last`.

## Operation
- **Handshake and stall**
  - A beat transfers when `in_valid && in_ready`.
  - A result transfers when `out_valid && out_ready`.
  - Global advance: `adv = !out_valid || out_ready`; `in_ready = adv` (combinational).
  - When `adv = 0`, every pipeline register, valid bit and the accumulator hold.
- **Tree**
  - `LEVELS` registered stages.
  - Level j pairs adjacent terms and produces ceil(n/2) sums, each one bit wider than the previous level, sign-extended.
  - An odd leftover term is sign-extended and passed through unchanged.
  - A valid bit and the `last` flag travel with the data.
  - Bubbles (valid = 0) propagate and never alter the accumulator.
- **Accumulator FSM**
  - States: IDLE (no partial sum held) and ACCUM (partial sum held).
  - On a valid tree output with the `last` flag:
    - From IDLE: `out_data` ← tree sum.
    - From ACCUM: `out_data` ← `acc` + tree sum.
    - Then `out_valid` ← 1, `out_err` ← 0, `acc` ← 0, `beat_cnt` ← 0, state → IDLE.
  - On a valid tree output without `last`:
    - `acc` ← (IDLE ? 0 : `acc`) + tree sum.
    - `beat_cnt` increments; state → ACCUM.
  - Force-close: on a valid, non-last tree output when `beat_cnt` = `MAX_BEATS`−1:
    - The result emits as if it were last, with `out_err` = 1; state → IDLE.
    - The following beat starts a new group.
  - `out_valid` clears on a result transfer unless a new result loads in the same cycle.
- **Arithmetic**
  - Two's complement throughout, with full sign extension to `OUT_WIDTH`.
  - No saturation is needed: a group of at most `MAX_BEATS` beats cannot overflow `OUT_WIDTH`.
- **Reset** (asynchronous, `reset` = 0):
  - All valid bits 0, `acc` = 0, `beat_cnt` = 0, state IDLE.
  - `out_data` = 0, `out_valid` = 0, `out_err` = 0.
  - `in_ready` = 1 immediately, because `out_valid` = 0.
  - Reset mid-group discards the partial sum. The first beat after deassertion starts a fresh group.

## Timing
- Latency: a `last` beat accepted at the edge of cycle t gives `out_valid` = 1 from cycle t+`LEVELS`+1, provided `out_ready` stayed 1. With `NUM_INPUTS` = 9 this is t+5.
- Throughput: one beat per cycle while `out_ready` = 1.
- Back-to-back single-beat groups (`in_last` = 1 on every beat) give one result per cycle.
- While `out_valid && !out_ready`, `in_ready` = 0 in the same cycle and `out_data`/`out_err` stay stable.
- Result transfer and new result load in the same cycle: the new value replaces the old one and `out_valid` stays 1.

## Structure
- Shared package `conv_pkg` holds:
  - the clog2 function;
  - the `LEVELS`/`OUT_WIDTH` derivation;
  - the IDLE/ACCUM state encoding.
- One sub-module, `reduce_tree_level`, parametrised by input count and input width. It is one registered pairwise level carrying valid/last and honouring `adv`. The top instantiates it `LEVELS` times in a generate loop.
- The accumulator, FSM and output register stay in the top module.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream.
  - Required: `out_valid`/`out_err`/`out_data` = 0 and `in_ready` = 1 at once.
  - Then a single last beat with all operands = 1 yields 9.
- **Single beat, signed:** operands 0..8 = {100, −50, 7, −7, 32767, −32768, 1, 0, −1}, `in_last` = 1.
  - Required: `out_data` = 49, `out_err` = 0, exactly 5 cycles after acceptance.
- **Accumulation:** 3 beats with all operands = 2, `in_last` on the third.
  - Required: one result, 54.
  - Required: no `out_valid` for beats 1–2.
- **Backpressure:** stream 4 single-beat groups with values 1, 2, 3, 4 (all operands equal), `out_ready` = 0 for 6 cycles.
  - Required: `in_ready` drops while the output is blocked.
  - Required: `out_data` holds 9 throughout.
  - Required: after release, results 9, 18, 27, 36 in order, none lost or duplicated.
- **Force-close:** 17 beats with all operands = −1, `in_last` never set.
  - Required: first result −144 with `out_err` = 1.
  - The 17th beat opens a new group.
- **Extremes:** 16 beats with all operands = −32768 and `in_last` on beat 16.
  - Required: −4718592 with no wrap and `out_err` = 0.
